// File: rtl/bsr_tile_scheduler_if.sv
// +----------------------------------------------------------------------------+
// | bsr_tile_scheduler_if                                                      |
// | Meta-table read channel and array/buffer beat bus of the BSR scheduler.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface bsr_tile_scheduler_if #(
  parameter int ADDR_W = 32
);
  logic              meta_ren;
  logic [ADDR_W-1:0] meta_raddr;
  logic [31:0]       meta_rdata;
  logic              meta_rvalid;
  logic              arr_ready;
  logic              wgt_rd_en;
  logic [ADDR_W-1:0] wgt_addr;
  logic              load_weight;
  logic              act_rd_en;
  logic [ADDR_W-1:0] act_addr;
  logic              pe_en;

  modport master (
    output meta_ren, meta_raddr, wgt_rd_en, wgt_addr, load_weight,
           act_rd_en, act_addr, pe_en,
    input  meta_rdata, meta_rvalid, arr_ready
  );

  modport slave (
    input  meta_ren, meta_raddr, wgt_rd_en, wgt_addr, load_weight,
           act_rd_en, act_addr, pe_en,
    output meta_rdata, meta_rvalid, arr_ready
  );
endinterface

`default_nettype wire

// File: rtl/bsr_tile_scheduler.sv
// +----------------------------------------------------------------------------+
// | bsr_tile_scheduler                                                         |
// | Block-Sparse Row walker: loads each non-zero weight block, streams M tiles.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module bsr_tile_scheduler #(
  parameter int M_W      = 10,
  parameter int K_W      = 12,
  parameter int ADDR_W   = 32,
  parameter int BLK      = 8,
  parameter int PTR_BASE = 0,
  parameter int COL_BASE = 128
) (
  input  wire logic           clk,
  input  wire logic           rst,
  input  wire logic           start,
  input  wire logic           abort,
  input  wire logic [M_W-1:0] MT,
  input  wire logic [K_W-1:0] KT,
  output logic                busy,
  output logic                done,
  output logic [31:0]         n_idx,
  output logic                row_err,
  output logic [31:0]         blk_cnt,
  output logic [K_W-1:0]      skip_cnt,
  bsr_tile_scheduler_if.master bus
);

  localparam int R_W = $clog2(BLK);
  localparam logic [R_W-1:0] C_R_LAST = R_W'(BLK - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PTR0, S_PTR1, S_CHECK, S_COL, S_LOAD, S_STREAM, S_NEXT_BLK, S_NEXT_K
  } state_t;

  state_t         state_q, state_d;
  logic [K_W-1:0] k_q, k_d, kt_q, kt_d, skip_cnt_q, skip_cnt_d;
  logic [M_W-1:0] m_q, m_d, mt_q, mt_d;
  logic [R_W-1:0] r_q, r_d;
  logic [31:0]    ptr_s_q, ptr_s_d, ptr_e_q, ptr_e_d, blk_ptr_q, blk_ptr_d;
  logic [31:0]    n_idx_q, n_idx_d, blk_cnt_q, blk_cnt_d;
  logic           row_err_q, row_err_d, busy_q, busy_d, done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      kt_q       <= '0;
      skip_cnt_q <= '0;
      m_q        <= '0;
      mt_q       <= '0;
      r_q        <= '0;
      ptr_s_q    <= '0;
      ptr_e_q    <= '0;
      blk_ptr_q  <= '0;
      n_idx_q    <= '0;
      blk_cnt_q  <= '0;
      row_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      kt_q       <= kt_d;
      skip_cnt_q <= skip_cnt_d;
      m_q        <= m_d;
      mt_q       <= mt_d;
      r_q        <= r_d;
      ptr_s_q    <= ptr_s_d;
      ptr_e_q    <= ptr_e_d;
      blk_ptr_q  <= blk_ptr_d;
      n_idx_q    <= n_idx_d;
      blk_cnt_q  <= blk_cnt_d;
      row_err_q  <= row_err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    kt_d       = kt_q;
    skip_cnt_d = skip_cnt_q;
    m_d        = m_q;
    mt_d       = mt_q;
    r_d        = r_q;
    ptr_s_d    = ptr_s_q;
    ptr_e_d    = ptr_e_q;
    blk_ptr_d  = blk_ptr_q;
    n_idx_d    = n_idx_q;
    blk_cnt_d  = blk_cnt_q;
    row_err_d  = row_err_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (MT == '0 || KT == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d     = 1'b1;
            k_d        = '0;
            mt_d       = MT;
            kt_d       = KT;
            blk_cnt_d  = '0;
            skip_cnt_d = '0;
            row_err_d  = 1'b0;
            state_d    = S_PTR0;
          end
        end
      end
      S_PTR0: begin
        if (bus.meta_rvalid) begin
          ptr_s_d = bus.meta_rdata;
          state_d = S_PTR1;
        end
      end
      S_PTR1: begin
        if (bus.meta_rvalid) begin
          ptr_e_d = bus.meta_rdata;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (ptr_e_q < ptr_s_q) begin
          row_err_d = 1'b1;
          state_d   = S_NEXT_K;
        end else if (ptr_e_q == ptr_s_q) begin
          if (skip_cnt_q != '1) skip_cnt_d = skip_cnt_q + K_W'(1);
          state_d = S_NEXT_K;
        end else begin
          blk_ptr_d = ptr_s_q;
          state_d   = S_COL;
        end
      end
      S_COL: begin
        if (bus.meta_rvalid) begin
          n_idx_d = bus.meta_rdata;
          r_d     = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.arr_ready) begin
          if (r_q == C_R_LAST) begin
            m_d     = '0;
            state_d = S_STREAM;
          end else begin
            r_d = r_q + R_W'(1);
          end
        end
      end
      S_STREAM: begin
        if (bus.arr_ready) begin
          if (m_q == mt_q - M_W'(1)) begin
            if (blk_cnt_q != '1) blk_cnt_d = blk_cnt_q + 32'd1;
            state_d = S_NEXT_BLK;
          end else begin
            m_d = m_q + M_W'(1);
          end
        end
      end
      S_NEXT_BLK: begin
        blk_ptr_d = blk_ptr_q + 32'd1;
        // 33-bit compare so a block pointer at all-ones cannot wrap past ptr_e
        if (({1'b0, blk_ptr_q} + 33'd1) < {1'b0, ptr_e_q}) state_d = S_COL;
        else                                                state_d = S_NEXT_K;
      end
      S_NEXT_K: begin
        if (k_q == kt_q - K_W'(1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          k_d     = k_q + K_W'(1);
          state_d = S_PTR0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Beat strobes and addresses decode directly from state and counters
  always_comb begin
    bus.meta_ren    = 1'b0;
    bus.meta_raddr  = '0;
    bus.wgt_rd_en   = 1'b0;
    bus.load_weight = 1'b0;
    bus.wgt_addr    = '0;
    bus.act_rd_en   = 1'b0;
    bus.pe_en       = 1'b0;
    bus.act_addr    = '0;
    case (state_q)
      S_PTR0: begin
        bus.meta_ren   = 1'b1;
        bus.meta_raddr = ADDR_W'(PTR_BASE) + ADDR_W'(k_q);
      end
      S_PTR1: begin
        bus.meta_ren   = 1'b1;
        bus.meta_raddr = ADDR_W'(PTR_BASE) + ADDR_W'(k_q) + ADDR_W'(1);
      end
      S_COL: begin
        bus.meta_ren   = 1'b1;
        bus.meta_raddr = ADDR_W'(COL_BASE) + ADDR_W'(blk_ptr_q);
      end
      S_LOAD: begin
        bus.wgt_rd_en   = bus.arr_ready;
        bus.load_weight = bus.arr_ready;
        bus.wgt_addr    = ADDR_W'(blk_ptr_q) * ADDR_W'(BLK) + ADDR_W'(r_q);
      end
      S_STREAM: begin
        bus.act_rd_en = bus.arr_ready;
        bus.pe_en     = bus.arr_ready;
        bus.act_addr  = ADDR_W'(m_q) * ADDR_W'(kt_q) + ADDR_W'(k_q);
      end
      default: ;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign n_idx    = n_idx_q;
  assign row_err  = row_err_q;
  assign blk_cnt  = blk_cnt_q;
  assign skip_cnt = skip_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_bsr_tile_scheduler.sv
// +----------------------------------------------------------------------------+
// | tb_bsr_tile_scheduler                                                      |
// | Scoreboard bench: directed schedules, meta latency, backpressure, abort.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bsr_tile_scheduler;
  localparam int M_W = 10;
  localparam int K_W = 12;
  localparam int ADDR_W = 32;
  localparam int BLK = 8;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [M_W-1:0] mt;
  logic [K_W-1:0] kt;
  logic busy, done, row_err;
  logic [31:0] n_idx, blk_cnt;
  logic [K_W-1:0] skip_cnt;

  bsr_tile_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  bsr_tile_scheduler #(
    .M_W(M_W), .K_W(K_W), .ADDR_W(ADDR_W), .BLK(BLK), .PTR_BASE(0), .COL_BASE(128)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .MT(mt), .KT(kt),
    .busy(busy), .done(done), .n_idx(n_idx), .row_err(row_err),
    .blk_cnt(blk_cnt), .skip_cnt(skip_cnt), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] n; } act_t;

  int          cmp_cnt = 0;
  int          err_cnt = 0;
  int          done_cnt = 0;
  bit          chk_en = 1'b1;
  bit          toggle_rdy = 1'b0;
  logic [31:0] mem [0:255];
  logic [31:0] wgt_q [$];
  act_t        act_q [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  task automatic push_blk(input int bp, input int n, input int k, input int mtv, input int ktv);
    act_t a;
    for (int r = 0; r < BLK; r++) wgt_q.push_back(32'(bp * BLK + r));
    for (int m = 0; m < mtv; m++) begin
      a.addr = 32'(m * ktv + k);
      a.n    = 32'(n);
      act_q.push_back(a);
    end
  endtask

  // Array readiness: steady high, or alternating to exercise stalls
  initial begin
    bus.arr_ready = 1'b1;
    forever begin
      tick();
      bus.arr_ready = toggle_rdy ? ~bus.arr_ready : 1'b1;
    end
  end

  // Meta memory responder with latency cycling 0..5 and address-stability check
  initial begin
    bit          active = 1'b0;
    int          cnt = 0;
    int          lat_seq = 0;
    logic [31:0] hold = '0;
    bus.meta_rvalid = 1'b0;
    bus.meta_rdata  = '0;
    forever begin
      tick();
      if (bus.meta_rvalid) active = 1'b0;
      bus.meta_rvalid = 1'b0;
      if (bus.meta_ren) begin
        if (!active) begin
          active  = 1'b1;
          cnt     = lat_seq;
          lat_seq = (lat_seq + 1) % 6;
          hold    = bus.meta_raddr;
        end else begin
          check("meta_raddr_stable", bus.meta_raddr, hold);
        end
        if (cnt == 0) begin
          bus.meta_rvalid = 1'b1;
          bus.meta_rdata  = mem[bus.meta_raddr[7:0]];
        end else begin
          cnt--;
        end
      end else begin
        active = 1'b0;
      end
    end
  end

  // Monitor: pops expected beats whenever the DUT presents one
  initial begin
    logic [31:0] e;
    act_t        a;
    logic        prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en && bus.wgt_rd_en) begin
        check("wgt_beat_expected", 64'(wgt_q.size() != 0), 64'd1);
        if (wgt_q.size() != 0) begin
          e = wgt_q.pop_front();
          check("wgt_addr", bus.wgt_addr, e);
          check("load_weight", bus.load_weight, 1);
        end
      end
      if (chk_en && bus.act_rd_en) begin
        check("act_beat_expected", 64'(act_q.size() != 0), 64'd1);
        if (act_q.size() != 0) begin
          a = act_q.pop_front();
          check("act_addr", bus.act_addr, a.addr);
          check("n_idx", n_idx, a.n);
          check("pe_en", bus.pe_en, 1);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_single_cycle", prev_done, 0);
      end
      prev_done = done;
    end
  end

  task automatic run(input int mtv, input int ktv, input int eblk, input int eskip, input int eerr);
    bit got = 1'b0;
    int d0 = done_cnt;
    mt = M_W'(mtv);
    kt = K_W'(ktv);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("done_seen", got, 1);
    check("busy_at_done", busy, 0);
    check("blk_cnt", blk_cnt, eblk);
    check("skip_cnt", skip_cnt, eskip);
    check("row_err", row_err, eerr);
    check("wgt_queue_drained", wgt_q.size(), 0);
    check("act_queue_drained", act_q.size(), 0);
    @(negedge clk);
    check("done_count", done_cnt - d0, 1);
    wgt_q.delete();
    act_q.delete();
  endtask

  task automatic setup_dense();
    clear_mem();
    mem[0] = 0; mem[1] = 1; mem[2] = 2;
    mem[128] = 1; mem[129] = 0;
    push_blk(0, 1, 0, 3, 2);
    push_blk(1, 0, 1, 3, 2);
  endtask

  initial begin
    bit got;
    int d0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mt = '0; kt = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_blk_cnt", blk_cnt, 0);
    check("rst_skip_cnt", skip_cnt, 0);
    check("rst_row_err", row_err, 0);
    check("rst_meta_ren", bus.meta_ren, 0);
    check("rst_wgt_rd_en", bus.wgt_rd_en, 0);
    check("rst_n_idx", n_idx, 0);

    // Dense 2x2: act addrs 0,2,4 then 1,3,5
    setup_dense();
    run(3, 2, 2, 0, 0);

    // Empty middle row
    clear_mem();
    mem[0] = 0; mem[1] = 2; mem[2] = 2; mem[3] = 3;
    mem[128] = 5; mem[129] = 6; mem[130] = 7;
    push_blk(0, 5, 0, 2, 3);
    push_blk(1, 6, 0, 2, 3);
    push_blk(2, 7, 2, 2, 3);
    run(2, 3, 3, 1, 0);

    // Malformed second row
    clear_mem();
    mem[0] = 0; mem[1] = 3; mem[2] = 1;
    mem[128] = 2; mem[129] = 3; mem[130] = 4;
    push_blk(0, 2, 0, 1, 2);
    push_blk(1, 3, 0, 1, 2);
    push_blk(2, 4, 0, 1, 2);
    run(1, 2, 3, 0, 1);

    // Backpressure
    toggle_rdy = 1'b1;
    setup_dense();
    run(3, 2, 2, 0, 0);
    toggle_rdy = 1'b0;

    // Abort mid-STREAM
    chk_en = 1'b0;
    clear_mem();
    mem[0] = 0; mem[1] = 1; mem[128] = 9;
    d0 = done_cnt;
    mt = M_W'(20); kt = K_W'(1);
    start = 1'b1; tick(); start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (bus.act_rd_en) got = 1'b1;
    end
    check("abort_reached_stream", got, 1);
    tick(); abort = 1'b1; tick(); abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_act_rd_en", bus.act_rd_en, 0);
    check("abort_meta_ren", bus.meta_ren, 0);
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    chk_en = 1'b1;
    setup_dense();
    run(3, 2, 2, 0, 0);

    // Reset during LOAD of the second block
    chk_en = 1'b0;
    clear_mem();
    mem[0] = 0; mem[1] = 1; mem[2] = 2; mem[128] = 1; mem[129] = 0;
    d0 = done_cnt;
    mt = M_W'(20); kt = K_W'(2);
    start = 1'b1; tick(); start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (bus.wgt_rd_en && blk_cnt == 32'd1) got = 1'b1;
    end
    check("rst_reached_load", got, 1);
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_wgt_rd_en", bus.wgt_rd_en, 0);
    check("midrst_blk_cnt", blk_cnt, 0);
    check("midrst_no_done", done_cnt - d0, 0);
    chk_en = 1'b1;
    setup_dense();
    run(3, 2, 2, 0, 0);

    // MT=0: done pulse only, no accesses
    mt = '0; kt = K_W'(2);
    start = 1'b1; tick(); start = 1'b0;
    @(negedge clk);
    check("mt0_done", done, 1);
    check("mt0_busy", busy, 0);
    check("mt0_meta_ren", bus.meta_ren, 0);
    @(negedge clk);
    check("mt0_done_drop", done, 0);

    // abort beats start in IDLE
    mt = M_W'(3); kt = K_W'(2);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_start_busy", busy, 0);
    check("abort_start_meta_ren", bus.meta_ren, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
